aes_key_expand_ctrl: RTL and testbench

//  Sequencer for the AES-128 byte-wide round-key memory (176 x 8b, async read, sync write, single shared addr).

---
 rtl/aes_key_expand_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 round-key sequencer: byte-serial key load, in-place expansion into a
// 176-byte round-key memory through a shared S-box, then 1-cycle byte reads.
module aes_key_expand_ctrl #(
  parameter int         NUM_BYTES = 176,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       key_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [7:0] sbox_in,
  input  logic [7:0] sbox_out,
  input  logic       rk_req,
  input  logic [7:0] rk_addr,
  output logic       rk_ack,
  output logic [7:0] rk_data,
  output logic       keys_valid,
  output logic       busy
);

  localparam logic [7:0] NUM_B8 = 8'(NUM_BYTES);
  localparam logic [7:0] LAST   = 8'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_EXP_A,
    S_EXP_B,
    S_EXP_W,
    S_READY
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] rcon;
  logic [7:0] a_reg;
  logic [7:0] t_reg;
  logic [7:0] t_next;
  logic [1:0] rot;
  logic       word_head;
  logic       rk_in_range;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // The first 4 bytes of each 16-byte round key go through RotWord/SubWord.
  assign word_head   = (cnt[3:2] == 2'b00);
  assign rot         = cnt[1:0] + 2'd1;
  assign rk_in_range = (rk_addr < NUM_B8);

  always_comb begin
    t_next = mem_rdata;
    if (word_head) begin
      t_next = (cnt[3:0] == 4'd0) ? (sbox_out ^ rcon) : sbox_out;
    end
  end

  always_comb begin
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    sbox_in   = 8'h00;
    case (state)
      S_LOAD: begin
        mem_addr = cnt;
        if (key_valid) begin
          mem_we    = 1'b1;
          mem_wdata = key_byte;
        end
      end
      S_EXP_A: mem_addr = cnt - 8'd16;
      S_EXP_B: begin
        if (word_head) begin
          // RotWord: byte (k+1)%4 of the previous word, which starts 4 bytes back
          mem_addr = {cnt[7:2], rot} - 8'd4;
          sbox_in  = mem_rdata;
        end else begin
          mem_addr = cnt - 8'd4;
        end
      end
      S_EXP_W: begin
        mem_addr  = cnt;
        mem_wdata = a_reg ^ t_reg;
        mem_we    = 1'b1;
      end
      S_READY: begin
        if (key_valid) begin
          mem_we    = 1'b1;
          mem_wdata = key_byte;
        end else if (rk_req && rk_in_range) begin
          mem_addr = rk_addr;
        end
      end
      default: ;
    endcase
  end

  assign key_ready  = (state == S_LOAD) || (state == S_READY);
  assign keys_valid = (state == S_READY) && !key_valid;
  assign busy       = ((state == S_LOAD) && (cnt != 8'd0)) ||
                      (state == S_EXP_A) || (state == S_EXP_B) || (state == S_EXP_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      cnt     <= 8'd0;
      rcon    <= RCON_INIT;
      rk_ack  <= 1'b0;
      rk_data <= 8'h00;
    end else begin
      rk_ack <= 1'b0;
      case (state)
        S_LOAD: begin
          if (key_valid) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'd15) state <= S_EXP_A;
          end
        end
        S_EXP_A: state <= S_EXP_B;
        S_EXP_B: state <= S_EXP_W;
        S_EXP_W: begin
          if (cnt[3:0] == 4'd3) rcon <= xtime(rcon);
          cnt   <= cnt + 8'd1;
          state <= (cnt == LAST) ? S_READY : S_EXP_A;
        end
        S_READY: begin
          if (key_valid) begin
            cnt   <= 8'd1;
            rcon  <= RCON_INIT;
            state <= S_LOAD;
          end else if (rk_req) begin
            rk_ack  <= 1'b1;
            rk_data <= rk_in_range ? mem_rdata : 8'h00;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Expansion operands: plain data registers, valid only within a byte's 3 cycles.
  always_ff @(posedge clk) begin
    if (state == S_EXP_A) a_reg <= mem_rdata;
    if (state == S_EXP_B) t_reg <= t_next;
  end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: memory and S-box models around the DUT, and a
// word-level AES-128 key schedule as the reference.
module tb_aes_key_expand_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_byte;
  logic       key_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic       rk_req;
  logic [7:0] rk_addr;
  logic       rk_ack;
  logic [7:0] rk_data;
  logic       keys_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_first = 0;

  logic [7:0] mem     [0:175];
  logic [7:0] key_bytes [0:15];
  logic [7:0] ref_rk  [0:175];
  logic [7:0] rd_buf  [0:175];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_expand_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_byte(key_byte),
    .key_ready(key_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .sbox_in(sbox_in),
    .sbox_out(sbox_out), .rk_req(rk_req), .rk_addr(rk_addr),
    .rk_ack(rk_ack), .rk_data(rk_data), .keys_valid(keys_valid), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always @(posedge clk) if (mem_we && mem_addr < 8'd176) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = (mem_addr < 8'd176) ? mem[mem_addr] : 8'h00;
  assign sbox_out  = sbox(sbox_in);

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic build_ref();
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  r = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = {key_bytes[4*i], key_bytes[4*i+1], key_bytes[4*i+2], key_bytes[4*i+3]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {r, 24'h0};
        r = xt(r);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++)
      for (int b = 0; b < 4; b++) ref_rk[4*i+b] = w[i][31-8*b -: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input bit gaps, input int first);
    for (int b = first; b < 16; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          key_valid = 1'b0;
          @(negedge clk);
          check_eq("gap_no_write", mem_we, 1'b0);
          tick();
        end
      end
      key_valid = 1'b1;
      key_byte  = key_bytes[b];
      @(negedge clk);
      if (b == 0) t_first = cyc;
      check_eq("load_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'(b), key_bytes[b]});
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int kv = -1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (keys_valid) begin
        kv = cyc;
        break;
      end
    end
    check_eq("ready_in_time", (kv >= 0), 1'b1);
    tick();
  endtask

  task automatic read_range(input int lo, input int hi);
    rk_req  = 1'b1;
    rk_addr = 8'(lo);
    tick();
    for (int a = lo; a <= hi; a++) begin
      if (a < hi) rk_addr = 8'(a + 1);
      else rk_req = 1'b0;
      @(negedge clk);
      check_eq("rd_ack", rk_ack, 1'b1);
      check_eq("rd_data", rk_data, (a < 176) ? ref_rk[a] : 8'h00);
      check_eq("rd_no_we", mem_we, 1'b0);
      if (a < 176) rd_buf[a] = rk_data;
      tick();
    end
    @(negedge clk);
    check_eq("rd_ack_end", rk_ack, 1'b0);
    tick();
  endtask

  task automatic set_key128(input logic [127:0] k);
    for (int b = 0; b < 16; b++) key_bytes[b] = k[127-8*b -: 8];
  endtask

  task automatic set_key_random();
    for (int b = 0; b < 16; b++) key_bytes[b] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kv;
    int ack_c;
    int noack_bad;
    logic [7:0] ack_d;

    for (int i = 0; i < 176; i++) mem[i] = 8'h00;
    rst = 1'b1; key_valid = 1'b0; key_byte = 8'h00; rk_req = 1'b0; rk_addr = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_flags", {key_ready, keys_valid, busy, rk_ack}, 4'b1000);
    check_eq("rst_outs", {rk_data, mem_we, mem_addr, mem_wdata, sbox_in}, 33'h0);
    tick();

    // FIPS-197 key, back-to-back, read request held from the first byte.
    set_key128(128'h2b7e151628aed2a6abf7158809cf4f3c);
    build_ref();
    rk_req = 1'b1;
    rk_addr = 8'd160;
    load_key(1'b0, 0);
    kv = -1; ack_c = -1; noack_bad = 0; ack_d = 8'h00;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (rk_ack) begin
        if (kv < 0) noack_bad++;
        else begin
          ack_c = cyc;
          ack_d = rk_data;
          break;
        end
      end
      if (keys_valid && kv < 0) kv = cyc;
    end
    check_eq("no_ack_while_busy", noack_bad, 0);
    check_eq("keys_valid_latency", kv - t_first, 496);
    check_eq("held_req_ack_latency", ack_c - kv, 1);
    check_eq("held_req_data", ack_d, 8'hd0);
    tick();
    rk_req = 1'b0;
    repeat (2) tick();
    check_eq("fips_w4", {mem[16], mem[17], mem[18], mem[19]}, 32'ha0fafe17);
    read_range(160, 175);
    check_eq("fips_round10", {rd_buf[160], rd_buf[161], rd_buf[162], rd_buf[163],
                              rd_buf[164], rd_buf[165], rd_buf[166], rd_buf[167],
                              rd_buf[168], rd_buf[169], rd_buf[170], rd_buf[171],
                              rd_buf[172], rd_buf[173], rd_buf[174], rd_buf[175]},
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_range(0, 175);

    // Random key, reset while expanding byte 40, then the all-zero key.
    set_key_random();
    key_bytes[0] = key_bytes[0] ^ 8'h5a;
    load_key(1'b0, 0);
    repeat (72) tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("byte40_exp_a_addr", mem_addr, 8'd24);
    check_eq("busy_mid_expand", busy, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("after_rst_flags", {key_ready, keys_valid, busy, mem_addr}, {3'b100, 8'h00});
    tick();
    set_key128(128'h0);
    build_ref();
    load_key(1'b0, 0);
    wait_ready();
    read_range(0, 175);
    check_eq("zero_round1", {rd_buf[16], rd_buf[17], rd_buf[18], rd_buf[19],
                             rd_buf[20], rd_buf[21], rd_buf[22], rd_buf[23],
                             rd_buf[24], rd_buf[25], rd_buf[26], rd_buf[27],
                             rd_buf[28], rd_buf[29], rd_buf[30], rd_buf[31]},
             128'h62636363626363636263636362636363);
    check_eq("zero_round10", {rd_buf[160], rd_buf[161], rd_buf[162], rd_buf[163],
                              rd_buf[164], rd_buf[165], rd_buf[166], rd_buf[167],
                              rd_buf[168], rd_buf[169], rd_buf[170], rd_buf[171],
                              rd_buf[172], rd_buf[173], rd_buf[174], rd_buf[175]},
             128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Out-of-range read.
    rk_req = 1'b1;
    rk_addr = 8'd200;
    @(negedge clk);
    check_eq("oob_addr_we", {mem_addr, mem_we}, 9'h0);
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    check_eq("oob_ack_data_we", {rk_ack, rk_data, mem_we}, {1'b1, 8'h00, 1'b0});
    tick();

    // New key from READY with a colliding read, gapped load, key_valid during expansion.
    for (int rep = 0; rep < 2; rep++) begin
      set_key_random();
      build_ref();
      key_valid = 1'b1;
      key_byte  = key_bytes[0];
      rk_req    = 1'b1;
      rk_addr   = 8'(5 + rep);
      @(negedge clk);
      check_eq("newkey_drop_kv", keys_valid, 1'b0);
      check_eq("newkey_write0", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h00, key_bytes[0]});
      tick();
      key_valid = 1'b0;
      rk_req    = 1'b0;
      @(negedge clk);
      check_eq("newkey_no_ack", rk_ack, 1'b0);
      check_eq("newkey_busy", busy, 1'b1);
      tick();
      load_key(1'b1, 1);
      repeat ($urandom_range(1, 20)) tick();
      for (int n = 0; n < 4; n++) begin
        key_valid = 1'b1;
        key_byte  = 8'($urandom);
        @(negedge clk);
        check_eq("exp_key_ready_low", key_ready, 1'b0);
        tick();
      end
      key_valid = 1'b0;
      wait_ready();
      read_range(0, 175);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
